// File: rtl/dram_ring_writer.sv
// Ring-buffer writer: streams samples to consecutive DRAM addresses with wrap, freezes after a
// post-trigger write count. Optional macro DROP_CNT_EN enables the saturating drop counter.
module dram_ring_writer #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned POST_TRIG = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              trig_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              din_valid_i,
  output logic [ADDR_W-1:0] dram_addr_o,
  output logic [DATA_W-1:0] dram_data_o,
  output logic              dram_wr_o,
  input  logic              dram_ack_i,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic              wrapped_o,
  output logic              overflow_o,
  output logic [15:0]       drop_cnt_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPost = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] PostLast = ADDR_W'(POST_TRIG - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_full_q, hold_full_d;
  logic                wrapped_q, wrapped_d;
  logic                overflow_q, overflow_d;
  logic                active, complete, last_wr, accept, drop;

  always_comb begin
    active   = ((state_q == StRun) || (state_q == StPost)) && en_i;
    complete = hold_full_q && dram_ack_i;
    last_wr  = (state_q == StPost) && complete && (post_cnt_q == PostLast);
    // The freezing write refuses a refill so exactly POST_TRIG writes follow the trigger.
    accept   = active && din_valid_i && (!hold_full_q || dram_ack_i) && !last_wr;
    drop     = active && din_valid_i && hold_full_q && !dram_ack_i;

    state_d     = state_q;
    addr_d      = addr_q;
    post_cnt_d  = post_cnt_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    wrapped_d   = wrapped_q;
    overflow_d  = overflow_q;

    if (complete) begin
      addr_d = addr_q + 1'b1;
      if (addr_q == '1) wrapped_d = 1'b1;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = din_i;
    end else if (complete) begin
      hold_full_d = 1'b0;
    end
    if (drop) overflow_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d    = StRun;
          addr_d     = '0;
          post_cnt_d = '0;
          wrapped_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end
      StRun: begin
        if (!en_i) begin
          if (!hold_full_q) state_d = StIdle;
        end else if (trig_i) begin
          state_d    = StPost;
          post_cnt_d = '0;
        end
      end
      StPost: begin
        if (last_wr) begin
          state_d = StDone;
        end else begin
          if (complete) post_cnt_d = post_cnt_q + 1'b1;
          if (!en_i && !hold_full_q) state_d = StIdle;
        end
      end
      StDone: begin
        if (!en_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      post_cnt_q  <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      wrapped_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      post_cnt_q  <= post_cnt_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      wrapped_q   <= wrapped_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q == StIdle) && en_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

  // The published pointer is one past the last completed write, which is the write address.
  assign dram_addr_o = addr_q;
  assign wr_ptr_o    = addr_q;
  assign dram_data_o = hold_data_q;
  assign dram_wr_o   = hold_full_q;
  assign state_o     = state_q;
  assign done_o      = (state_q == StDone);
  assign wrapped_o   = wrapped_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_dram_ring_writer.sv
// Directed bench for dram_ring_writer: vector table plus wrap, post-trigger and reset sequences.
module tb_dram_ring_writer;

  logic        clk_i = 1'b0;
  logic        rst_ni, en_i, trig_i, din_valid_i, dram_ack_i;
  logic [31:0] din_i;
  logic [3:0]  dram_addr_o, wr_ptr_o;
  logic [31:0] dram_data_o;
  logic        dram_wr_o, done_o, wrapped_o, overflow_o;
  logic [1:0]  state_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;
  int nwr    = 0;

`ifdef DROP_CNT_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  dram_ring_writer #(
    .ADDR_W   (4),
    .DATA_W   (32),
    .POST_TRIG(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .trig_i     (trig_i),
    .din_i      (din_i),
    .din_valid_i(din_valid_i),
    .dram_addr_o(dram_addr_o),
    .dram_data_o(dram_data_o),
    .dram_wr_o  (dram_wr_o),
    .dram_ack_i (dram_ack_i),
    .wr_ptr_o   (wr_ptr_o),
    .state_o    (state_o),
    .done_o     (done_o),
    .wrapped_o  (wrapped_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 ns after posedge, so the negedge sees what the next posedge will see.
  always @(negedge clk_i) if (dram_wr_o && dram_ack_i) nwr <= nwr + 1;

  typedef struct {
    logic        en, trig, dv;
    logic [31:0] din;
    logic        ack, cd;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        wr;
    logic [3:0]  ptr;
    logic [1:0]  st;
    logic        ovf;
    logic [15:0] drp;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //        en    trig  dv    din       ack   cd    addr  data      wr    ptr   st    ovf   drp
    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 2'd1, 1'b0, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 32'hA0,  1'b1, 1'b1, 4'd0, 32'hA0,  1'b1, 4'd0, 2'd1, 1'b0, 16'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 32'hA1,  1'b1, 1'b1, 4'd1, 32'hA1,  1'b1, 4'd1, 2'd1, 1'b0, 16'd0};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 32'hA2,  1'b1, 1'b1, 4'd2, 32'hA2,  1'b1, 4'd2, 2'd1, 1'b0, 16'd0};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 32'hA3,  1'b1, 1'b1, 4'd3, 32'hA3,  1'b1, 4'd3, 2'd1, 1'b0, 16'd0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 32'hA4,  1'b1, 1'b1, 4'd4, 32'hA4,  1'b1, 4'd4, 2'd1, 1'b0, 16'd0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 4'd5, 32'h0,   1'b0, 4'd5, 2'd1, 1'b0, 16'd0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 4'd5, 32'h0,   1'b0, 4'd5, 2'd0, 1'b0, 16'd0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 2'd1, 1'b0, 16'd0};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 32'hB0,  1'b0, 1'b1, 4'd0, 32'hB0,  1'b1, 4'd0, 2'd1, 1'b0, 16'd0};
    vt[10] = '{1'b1, 1'b0, 1'b1, 32'hB1,  1'b0, 1'b1, 4'd0, 32'hB0,  1'b1, 4'd0, 2'd1, 1'b1, 16'd1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 32'hB2,  1'b0, 1'b1, 4'd0, 32'hB0,  1'b1, 4'd0, 2'd1, 1'b1, 16'd2};
    vt[12] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 4'd1, 32'h0,   1'b0, 4'd1, 2'd1, 1'b1, 16'd2};
    vt[13] = '{1'b1, 1'b0, 1'b1, 32'hC0,  1'b0, 1'b1, 4'd1, 32'hC0,  1'b1, 4'd1, 2'd1, 1'b1, 16'd2};
    vt[14] = '{1'b1, 1'b0, 1'b1, 32'hC1,  1'b1, 1'b1, 4'd2, 32'hC1,  1'b1, 4'd2, 2'd1, 1'b1, 16'd2};
    vt[15] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 4'd3, 32'h0,   1'b0, 4'd3, 2'd1, 1'b1, 16'd2};
    vt[16] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 4'd3, 32'h0,   1'b0, 4'd3, 2'd0, 1'b1, 16'd2};
    vt[17] = '{1'b0, 1'b1, 1'b1, 32'hEE,  1'b1, 1'b0, 4'd3, 32'h0,   1'b0, 4'd3, 2'd0, 1'b1, 16'd2};

    rst_ni = 1'b1; en_i = 1'b0; trig_i = 1'b0; din_valid_i = 1'b0; din_i = '0; dram_ack_i = 1'b0;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst addr", 32'(dram_addr_o), 32'd0);
    chk("rst data", dram_data_o, 32'd0);
    chk("rst wr", 32'(dram_wr_o), 32'd0);
    chk("rst ptr", 32'(wr_ptr_o), 32'd0);
    chk("rst state", 32'(state_o), 32'd0);
    chk("rst flags", 32'({done_o, wrapped_o, overflow_o}), 32'd0);
    chk("rst drop", 32'(drop_cnt_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) begin
      en_i = vt[i].en; trig_i = vt[i].trig; din_valid_i = vt[i].dv;
      din_i = vt[i].din; dram_ack_i = vt[i].ack;
      step();
      chk($sformatf("v%0d addr", i), 32'(dram_addr_o), 32'(vt[i].addr));
      chk($sformatf("v%0d wr", i), 32'(dram_wr_o), 32'(vt[i].wr));
      chk($sformatf("v%0d ptr", i), 32'(wr_ptr_o), 32'(vt[i].ptr));
      chk($sformatf("v%0d state", i), 32'(state_o), 32'(vt[i].st));
      chk($sformatf("v%0d ovf", i), 32'(overflow_o), 32'(vt[i].ovf));
      chk($sformatf("v%0d drop", i), 32'(drop_cnt_o), DropEn ? 32'(vt[i].drp) : 32'd0);
      if (vt[i].cd) chk($sformatf("v%0d data", i), dram_data_o, vt[i].data);
    end

    // Wrap: 18 back-to-back samples through a 16-word ring.
    en_i = 1'b1; trig_i = 1'b0; din_valid_i = 1'b0; dram_ack_i = 1'b1;
    step();
    for (int k = 0; k < 18; k++) begin
      din_valid_i = 1'b1; din_i = 32'h100 + 32'(k);
      step();
      chk($sformatf("wrap%0d addr", k), 32'(dram_addr_o), 32'(k % 16));
      chk($sformatf("wrap%0d flag", k), 32'(wrapped_o), (k >= 16) ? 32'd1 : 32'd0);
      chk($sformatf("wrap%0d data", k), dram_data_o, 32'h100 + 32'(k));
    end
    din_valid_i = 1'b0;
    step();
    chk("wrap ptr", 32'(wr_ptr_o), 32'd2);
    chk("wrap wr", 32'(dram_wr_o), 32'd0);
    chk("wrap sticky", 32'(wrapped_o), 32'd1);

    // Post-trigger freeze after 10 pre-trigger writes.
    en_i = 1'b0;
    step();
    chk("idle state", 32'(state_o), 32'd0);
    en_i = 1'b1;
    step();
    chk("rearm wrapped", 32'(wrapped_o), 32'd0);
    chk("rearm ptr", 32'(wr_ptr_o), 32'd0);
    for (int k = 0; k < 10; k++) begin
      din_valid_i = 1'b1; din_i = 32'h200 + 32'(k);
      step();
    end
    din_valid_i = 1'b0;
    step();
    chk("pre ptr", 32'(wr_ptr_o), 32'd10);
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    chk("trig state", 32'(state_o), 32'd2);
    begin
      int n0;
      n0 = nwr;
      for (int k = 0; k < 7; k++) begin
        din_valid_i = 1'b1; din_i = 32'h300 + 32'(k);
        step();
        if (k == 3) chk("post state", 32'(state_o), 32'd2);
      end
      chk("post writes", 32'(nwr - n0), 32'd4);
    end
    chk("done state", 32'(state_o), 32'd3);
    chk("done flag", 32'(done_o), 32'd1);
    chk("done ptr", 32'(wr_ptr_o), 32'd14);
    chk("done wr", 32'(dram_wr_o), 32'd0);
    chk("done ovf", 32'(overflow_o), 32'd0);
    chk("done drop", 32'(drop_cnt_o), 32'd0);
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    chk("done trig", 32'(state_o), 32'd3);
    din_valid_i = 1'b0; en_i = 1'b0;
    step();
    chk("disarm state", 32'(state_o), 32'd0);
    chk("disarm done", 32'(done_o), 32'd0);
    chk("disarm ptr", 32'(wr_ptr_o), 32'd14);

    // Reset in the middle of a pending write.
    en_i = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      din_valid_i = 1'b1; din_i = 32'h400 + 32'(k);
      step();
    end
    din_valid_i = 1'b0;
    step();
    din_valid_i = 1'b1; din_i = 32'hD0; dram_ack_i = 1'b0;
    step();
    din_valid_i = 1'b0;
    chk("pend addr", 32'(dram_addr_o), 32'd3);
    chk("pend wr", 32'(dram_wr_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst wr", 32'(dram_wr_o), 32'd0);
    chk("arst addr", 32'(dram_addr_o), 32'd0);
    chk("arst ptr", 32'(wr_ptr_o), 32'd0);
    chk("arst data", dram_data_o, 32'd0);
    chk("arst state", 32'(state_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    chk("restart state", 32'(state_o), 32'd1);
    din_valid_i = 1'b1; din_i = 32'hE0;
    step();
    din_valid_i = 1'b0;
    chk("restart addr", 32'(dram_addr_o), 32'd0);
    chk("restart data", dram_data_o, 32'hE0);
    chk("restart wr", 32'(dram_wr_o), 32'd1);
    dram_ack_i = 1'b1;
    step();
    chk("restart ptr", 32'(wr_ptr_o), 32'd1);
    chk("restart drain", 32'(dram_wr_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_ring_writer.md
# dram_ring_writer

Upstream producer of the DRAM ring buffer: accepts a sample stream, writes each sample to consecutive DRAM addresses with wrap-around, and publishes the next-write pointer. The downstream DRAM read controller uses that pointer as its stop/compare value. A trigger freezes the ring after a programmable number of post-trigger writes, leaving pre- and post-trigger history in DRAM for readout.

## Interface
- `ADDR_W`, 24: DRAM word-address width; must equal the reader's address width.
- `DATA_W`, 32: sample and DRAM data width.
- `POST_TRIG`, 1024: completed writes after trigger before freeze; range 1..2^ADDR_W-1.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: arm; level-sensitive.
- `trig` in 1: capture trigger; sampled only in RUN.
- `din` in DATA_W: sample data.
- `din_valid` in 1: one-cycle sample strobe; no backpressure.
- `dram_addr` out ADDR_W: write address.
- `dram_data` out DATA_W: write data.
- `dram_wr` out 1: write request; held until acked.
- `dram_ack` in 1: DRAM accepted current write.
- `wr_ptr` out ADDR_W: next address to be written, i.e. one past the last completed write; feeds the reader's compare input.
- `state` out 2: IDLE=0, RUN=1, POST=2, DONE=3.
- `done` out 1: high in DONE.
- `wrapped` out 1: sticky; set when the address first wraps to 0.
- `overflow` out 1: sticky; a sample was dropped.
- `drop_cnt` out 16: dropped-sample count; see Configuration.

## Operation
- Holding register: one entry, `hold_full` flag. `dram_data`/`dram_addr` are driven from the holding register and address counter.
- Sample accept: in RUN or POST, `din_valid` loads the holding register if it is empty, or if it is full and `dram_ack` is high that cycle (simultaneous drain and fill).
- Sample drop: `din_valid` while the register is full and `dram_ack` is low drops the sample. This sets `overflow` and increments `drop_cnt`, saturating at 0xFFFF.
- `dram_wr` equals `hold_full`.
- Write completion: `dram_ack` is sampled only while `dram_wr` is high. On completion, the address becomes `(addr+1) mod 2^ADDR_W` and `wr_ptr` takes the same value.
- Wrap: when the address wraps from all-ones to 0, `wrapped` is set.
- FSM transitions:
  - IDLE→RUN when `en` is high. On this transition, address, `wr_ptr`, `wrapped`, `overflow`, `drop_cnt` and `post_cnt` clear to 0.
  - RUN→POST when `trig` is high. `post_cnt` clears. A sample arriving in the trigger cycle is accepted normally.
  - POST: each completion increments `post_cnt`. On the completion with `post_cnt == POST_TRIG-1`, go to DONE.
  - DONE: `din_valid` is ignored and no drop is counted. Go to IDLE when `en` is low. Pointer and flags hold for readout.
  - `en` low in RUN or POST: new samples are ignored. Any held sample completes its write. Then go to IDLE on the cycle after the register is empty, or immediately if it is already empty.
- `trig` in IDLE, POST or DONE is ignored.

## Timing
- Reset values: `dram_addr`=0, `dram_data`=0, `dram_wr`=0, `wr_ptr`=0, `state`=IDLE, `done`=0, `wrapped`=0, `overflow`=0, `drop_cnt`=0, holding register empty.
- Reset asserted mid-write: `dram_wr` drops asynchronously and the write is abandoned.
- `din_valid` at edge N: `dram_wr` is high after edge N.
- `dram_ack` high at edge M: `wr_ptr` and `dram_addr` advance after edge M, and `dram_wr` drops after edge M unless the register was refilled at M.
- Sustained throughput: one sample per cycle when `dram_ack` is tied high.
- `state` and `done` are registered; `done` asserts after the final completion edge.

## Configuration
- `DROP_CNT_EN` defined: the 16-bit saturating `drop_cnt` is implemented.
- `DROP_CNT_EN` undefined: `drop_cnt` is tied to 0 and its counter logic is removed. `overflow` still works.

## Test plan
- Reset, then `en`=1, 5 samples 0xA0..0xA4 with `dram_ack` tied 1 → addresses 0..4 written with matching data; `wr_ptr`=5; `overflow`=0.
- `dram_ack` held 0 for 3 cycles while `din_valid` pulses on each → first sample held; 2 drops; `overflow`=1; `drop_cnt`=2 (0 without `DROP_CNT_EN`); after ack, `wr_ptr`=1.
- `ADDR_W`=4, 18 samples → writes at 15 then 0, 1; `wrapped`=1; `wr_ptr`=2.
- `POST_TRIG`=4, `trig` after 10 writes → exactly 4 more writes; DONE with `wr_ptr`=14; later `din_valid` ignored; `en`=0 → IDLE.
- `din_valid` and `dram_ack` in the same cycle with the register full → new sample accepted; no drop; consecutive addresses.
- Assert `rst` low while `dram_wr`=1 → all outputs at reset values immediately; after release with `en`=1, writing restarts at address 0.
